// File: rtl/mac_accumulator_pkg.sv
// Shared types and arithmetic helpers for the MAC accumulator slice.
// Defines the multiplier product and activation widths when the build does not supply them.
`ifndef MULT_OUT_SIZE
`define MULT_OUT_SIZE 8
`endif
`ifndef IFDATA_SIZE
`define IFDATA_SIZE 8
`endif

package mac_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } state_t;

    localparam int ACC_FRAC  = 5;
    localparam int OUT_FRAC  = 7;
    localparam int REQ_SHIFT = OUT_FRAC - ACC_FRAC;

    // Operands arrive sign-extended to 32 bits. The sum is formed one bit wider,
    // so it cannot overflow before it is clamped to a w-bit signed range.
    function automatic logic signed [32:0] wide_sum(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        return $signed({a[31], a}) + $signed({b[31], b});
    endfunction

    function automatic logic signed [32:0] acc_max(input int w);
        return (33'sd1 <<< (w - 1)) - 33'sd1;
    endfunction

    function automatic logic sat_hit(input logic signed [31:0] a,
                                     input logic signed [31:0] b,
                                     input int w);
        logic signed [32:0] s;
        s = wide_sum(a, b);
        return (s > acc_max(w)) || (s < (-acc_max(w) - 33'sd1));
    endfunction

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = wide_sum(a, b);
        hi = acc_max(w);
        lo = -hi - 33'sd1;
        if (s > hi)
            return hi[31:0];
        else if (s < lo)
            return lo[31:0];
        else
            return s[31:0];
    endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Handshake bundle between the MAC accumulator and its producer and consumer.
// The MAC_BIAS_EN build adds bias_in, which is sampled together with start.
interface mac_accumulator_if #(
    parameter int LEN_W = 8
);
    logic                      start;
    logic [LEN_W-1:0]          cfg_len;
    logic                      in_valid;
    logic                      in_ready;
    logic [`MULT_OUT_SIZE-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [`IFDATA_SIZE-1:0]   out_data;
    logic                      out_sat;
    logic                      busy;
`ifdef MAC_BIAS_EN
    logic [`MULT_OUT_SIZE-1:0] bias_in;

    modport master (
        output start, cfg_len, in_valid, in_data, out_ready, bias_in,
        input  in_ready, out_valid, out_data, out_sat, busy
    );
    modport slave (
        input  start, cfg_len, in_valid, in_data, out_ready, bias_in,
        output in_ready, out_valid, out_data, out_sat, busy
    );
`else
    modport master (
        output start, cfg_len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );
    modport slave (
        input  start, cfg_len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
`endif
endinterface

// File: rtl/mac_requant.sv
// Converts the signed Q.5 accumulator into an unsigned Q.7 activation code.
// Negative sums and zero map to 0. Codes above full scale clamp to all-ones and raise sat.
module mac_requant
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic signed [ACC_W-1:0]        acc,
    output logic        [`IFDATA_SIZE-1:0] code,
    output logic                           sat
);
    localparam int CW = ACC_W + REQ_SHIFT;
    localparam logic signed [CW-1:0] CODE_MAX = CW'((1 << `IFDATA_SIZE) - 1);

    logic signed [CW-1:0] wide;

    always_comb begin
        wide = CW'(acc) <<< REQ_SHIFT;
        code = '0;
        sat  = 1'b0;
        if (acc[ACC_W-1] || (acc == '0)) begin
            code = '0;
        end else if (wide > CODE_MAX) begin
            code = '1;
            sat  = 1'b1;
        end else begin
            code = wide[`IFDATA_SIZE-1:0];
        end
    end
endmodule

// File: rtl/mac_accumulator.sv
// Windowed saturating MAC accumulator. The result is requantized to the Q.7 activation format.
// Optional MAC_BIAS_EN: the accumulator is seeded with bias_in when a window starts.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int LEN_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    mac_accumulator_if.slave  bus
);
    localparam int PW = `MULT_OUT_SIZE;

    state_t                  state_reg, state_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next, acc_init;
    logic [LEN_W-1:0]        count_reg, count_next;
    logic [LEN_W-1:0]        len_reg, len_next;
    logic                    sat_reg, sat_next;
    logic [`IFDATA_SIZE-1:0] out_data_reg;
    logic                    out_sat_reg;
    logic signed [PW-1:0]    in_prod;
    logic                    xfer, last_xfer, load_out;
    logic [`IFDATA_SIZE-1:0] rq_code;
    logic                    rq_sat;

    assign in_prod   = $signed(bus.in_data);
    assign xfer      = (state_reg == ACCUM) && bus.in_valid;
    assign last_xfer = xfer && (count_reg == len_reg - LEN_W'(1));
    assign load_out  = (state_reg != OUTPUT) && (state_next == OUTPUT);

`ifdef MAC_BIAS_EN
    assign acc_init = ACC_W'($signed(bus.bias_in));
`else
    assign acc_init = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = (bus.cfg_len == '0) ? OUTPUT : ACCUM;
            ACCUM:   if (last_xfer) state_next = OUTPUT;
            OUTPUT:  if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_reg == ACCUM);
        bus.out_valid = (state_reg == OUTPUT);
        bus.busy      = (state_reg != IDLE);
        bus.out_data  = out_data_reg;
        bus.out_sat   = out_sat_reg;
    end

    // Window datapath. acc_next also feeds the requantizer, so the result is ready the cycle after the last transfer.
    always_comb begin
        acc_next   = acc_reg;
        count_next = count_reg;
        len_next   = len_reg;
        sat_next   = sat_reg;
        if (state_reg == IDLE && bus.start) begin
            len_next   = bus.cfg_len;
            acc_next   = acc_init;
            count_next = '0;
            sat_next   = 1'b0;
        end else if (xfer) begin
            acc_next   = ACC_W'(sat_add(32'(acc_reg), 32'(in_prod), ACC_W));
            count_next = count_reg + LEN_W'(1);
            sat_next   = sat_reg | sat_hit(32'(acc_reg), 32'(in_prod), ACC_W);
        end
    end

    mac_requant #(.ACC_W(ACC_W)) u_requant (
        .acc  (acc_next),
        .code (rq_code),
        .sat  (rq_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg      <= '0;
            count_reg    <= '0;
            len_reg      <= '0;
            sat_reg      <= 1'b0;
            out_data_reg <= '0;
            out_sat_reg  <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            count_reg <= count_next;
            len_reg   <= len_next;
            sat_reg   <= sat_next;
            if (load_out) begin
                out_data_reg <= rq_code;
                out_sat_reg  <= sat_next | rq_sat;
            end
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator (ACC_W=16 and ACC_W=12 instances).
module tb_mac_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_accumulator_if #(.LEN_W(8)) bus ();
    mac_accumulator_if #(.LEN_W(8)) bus12 ();

    mac_accumulator #(.ACC_W(16), .LEN_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mac_accumulator #(.ACC_W(12), .LEN_W(8)) u_dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus12.slave)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] prod_mem [0:63];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int len, input bit gaps, input string name);
        bus.start   = 1'b1;
        bus.cfg_len = 8'(len);
        step();
        bus.start = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                step();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = prod_mem[i];
            step();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_latency: out_valid=%b required 1", name, bus.out_valid);
        end
        $display("%s: window len=%0d fed", name, len);
    endtask

    task automatic collect(input logic [7:0] exp_data, input logic exp_sat, input string name);
        int t;
        t = 0;
        while (bus.out_valid !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        n_checks++;
        if (bus.out_data !== exp_data) begin
            n_fail++;
            $display("FAIL %s_data: out_data=%0d required %0d", name, bus.out_data, exp_data);
        end
        n_checks++;
        if (bus.out_sat !== exp_sat) begin
            n_fail++;
            $display("FAIL %s_sat: out_sat=%b required %b", name, bus.out_sat, exp_sat);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: out_valid=%b required 0", name, bus.out_valid);
        end
        $display("%s: result data=%0d sat=%b", name, bus.out_data, bus.out_sat);
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_sat, bus.busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_data=%0d out_sat=%b busy=%b required all 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_sat, bus.busy);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b required 0", bus.busy);
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) prod_mem[i] = 8'd8;
        feed(3, 1'b0, "basic");
        collect(8'd96, 1'b0, "basic");
    endtask

    task automatic test_negative();
        for (int i = 0; i < 2; i++) prod_mem[i] = 8'hF0;
        feed(2, 1'b0, "negative");
        collect(8'd0, 1'b0, "negative");
    endtask

    task automatic test_out_clamp();
        for (int i = 0; i < 4; i++) prod_mem[i] = 8'd32;
        feed(4, 1'b0, "out_clamp");
        collect(8'd255, 1'b1, "out_clamp");
    endtask

    task automatic test_acc12();
        int t;
        bus12.start   = 1'b1;
        bus12.cfg_len = 8'd40;
        step();
        bus12.start    = 1'b0;
        bus12.in_valid = 1'b1;
        bus12.in_data  = 8'd127;
        t = 0;
        while (bus12.out_valid !== 1'b1 && t < 60) begin
            step();
            t++;
        end
        bus12.in_valid = 1'b0;
        n_checks++;
        if (t != 40) begin
            n_fail++;
            $display("FAIL acc12_count: cycles to out_valid=%0d required 40", t);
        end
        n_checks++;
        if (bus12.out_data !== 8'd255 || bus12.out_sat !== 1'b1) begin
            n_fail++;
            $display("FAIL acc12_clamp: out_data=%0d out_sat=%b required 255/1", bus12.out_data, bus12.out_sat);
        end
        bus12.out_ready = 1'b1;
        step();
        bus12.out_ready = 1'b0;
        bus12.start     = 1'b1;
        bus12.cfg_len   = 8'd0;
        step();
        bus12.start = 1'b0;
        n_checks++;
        if (bus12.out_valid !== 1'b1 || bus12.out_data !== 8'd0 || bus12.out_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL acc12_len0: out_valid=%b out_data=%0d out_sat=%b required 1/0/0",
                     bus12.out_valid, bus12.out_data, bus12.out_sat);
        end
        bus12.out_ready = 1'b1;
        step();
        bus12.out_ready = 1'b0;
        $display("test_acc12: len40 and len0 windows done");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) prod_mem[i] = 8'd8;
        feed(3, 1'b0, "backpressure");
        for (int c = 0; c < 5; c++) begin
            bus.start    = (c == 2);
            bus.cfg_len  = 8'd5;
            bus.in_valid = (c >= 1);
            bus.in_data  = 8'd8;
            step();
            n_checks++;
            if (bus.out_data !== 8'd96 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure_hold: out_data=%0d in_ready=%b out_valid=%b required 96/0/1",
                         bus.out_data, bus.in_ready, bus.out_valid);
            end
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        collect(8'd96, 1'b0, "backpressure");
        step();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_ignored_start: busy=%b required 0", bus.busy);
        end
        feed(3, 1'b1, "gaps");
        collect(8'd96, 1'b0, "gaps");
    endtask

    task automatic test_reset_mid();
        bus.start   = 1'b1;
        bus.cfg_len = 8'd4;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd8;
        step();
        step();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_sat, bus.busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b out_data=%0d out_sat=%b busy=%b required all 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_sat, bus.busy);
        end
        step();
        rst_n = 1'b1;
        step();
        prod_mem[0] = 8'd4;
        feed(1, 1'b0, "after_reset");
        collect(8'd16, 1'b0, "after_reset");
    endtask

    initial begin
        bus.start = 1'b0;   bus.cfg_len = '0;   bus.in_valid = 1'b0;
        bus.in_data = '0;   bus.out_ready = 1'b0;
        bus12.start = 1'b0; bus12.cfg_len = '0; bus12.in_valid = 1'b0;
        bus12.in_data = '0; bus12.out_ready = 1'b0;
`ifdef MAC_BIAS_EN
        bus.bias_in   = '0;
        bus12.bias_in = '0;
`endif
        test_reset();
        test_basic();
        test_negative();
        test_out_clamp();
        test_acc12();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
